// File: rtl/controlador_de_interrupcao.sv
// controlador_de_interrupcao
//   Interrupt controller sitting between the peripherals and the control unit.
//   Latches disk / input-device requests (and optionally a user-mode time-slice
//   expiry) as pending bits. While a user process is running, it grants the
//   highest-priority pending source (disk > IO > timer). The grant is then
//   handshaked through REQ (intr high) -> SERV (after inta) -> IDLE (after
//   clearIntr).
//
//   Optional feature: define TIMER_QUANTUM_EN to build the quantum counter that
//   raises pending[0] every QUANTUM cycles spent running in IDLE. Without the
//   macro, pending[0] is constant 0 and code 1 is never issued.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   userMode   in   exec/exec_again pulse (process entry, sets running)
//   kernelMode in   syscall pulse (kernel entry, clears running)
//   inta       in   interrupt acknowledge (REQ -> SERV)
//   clearIntr  in   retire current interrupt (REQ/SERV -> IDLE)
//   reqDisk    in   one-cycle disk-done request
//   reqIO      in   one-cycle input-device request
//   intr       out  interrupt request, high only in REQ
//   intCode    out  latched code: 0 none, 1 timer, 2 disk, 3 IO
//   pending    out  pending bits {io, disk, timer}
module controlador_de_interrupcao #(
  parameter int QUANTUM = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       userMode,
  input  logic       kernelMode,
  input  logic       inta,
  input  logic       clearIntr,
  input  logic       reqDisk,
  input  logic       reqIO,
  output logic       intr,
  output logic [1:0] intCode,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t     r_state;
  logic       r_running;
  logic       r_pend_disk;
  logic       r_pend_io;
  logic       r_intr;
  logic [1:0] r_code;

  logic w_pend_tmr;
  logic w_grant;
  logic w_gnt_disk;
  logic w_gnt_io;
  logic w_gnt_tmr;

  // Grants only come from registered pending bits, so a request arriving in
  // the grant cycle is simply re-latched (set wins over clear).
  assign w_grant    = (r_state == IDLE) && r_running &&
                      (r_pend_disk || r_pend_io || w_pend_tmr);
  assign w_gnt_disk = w_grant && r_pend_disk;
  assign w_gnt_io   = w_grant && !r_pend_disk && r_pend_io;
  assign w_gnt_tmr  = w_grant && !r_pend_disk && !r_pend_io && w_pend_tmr;

  // running flag: userMode wins over kernelMode in the same cycle
  always_ff @(posedge clk) begin
    if (reset)           r_running <= 1'b0;
    else if (userMode)   r_running <= 1'b1;
    else if (kernelMode) r_running <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_disk <= 1'b0;
      r_pend_io   <= 1'b0;
    end else begin
      r_pend_disk <= reqDisk | (r_pend_disk & ~w_gnt_disk);
      r_pend_io   <= reqIO   | (r_pend_io   & ~w_gnt_io);
    end
  end

`ifdef TIMER_QUANTUM_EN
  logic [15:0] r_qcnt;
  logic        r_pend_tmr;
  logic        w_qinc;
  logic        w_qhit;

  // Counter advances only while a process runs and no interrupt is in flight;
  // a fresh userMode restarts the slice.
  assign w_qinc = !userMode && r_running && (r_state == IDLE);
  assign w_qhit = w_qinc && (r_qcnt == 16'(QUANTUM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_qcnt     <= 16'd0;
      r_pend_tmr <= 1'b0;
    end else begin
      if (userMode)    r_qcnt <= 16'd0;
      else if (w_qhit) r_qcnt <= 16'd0;
      else if (w_qinc) r_qcnt <= r_qcnt + 16'd1;
      r_pend_tmr <= w_qhit | (r_pend_tmr & ~w_gnt_tmr);
    end
  end

  assign w_pend_tmr = r_pend_tmr;
`else
  logic w_unused_quantum;
  assign w_unused_quantum = (QUANTUM == 0) | w_gnt_tmr;
  assign w_pend_tmr       = 1'b0;
`endif

  // Handshake FSM with registered intr / intCode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_intr  <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= REQ;
            r_intr  <= 1'b1;
            r_code  <= w_gnt_disk ? 2'd2 : (w_gnt_io ? 2'd3 : 2'd1);
          end
        end
        REQ: begin
          if (clearIntr) begin
            r_state <= IDLE;
            r_intr  <= 1'b0;
            r_code  <= 2'd0;
          end else if (inta) begin
            r_state <= SERV;
            r_intr  <= 1'b0;
          end
        end
        SERV: begin
          if (clearIntr) begin
            r_state <= IDLE;
            r_code  <= 2'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_intr  <= 1'b0;
          r_code  <= 2'd0;
        end
      endcase
    end
  end

  assign intr    = r_intr;
  assign intCode = r_code;
  assign pending = {r_pend_io, r_pend_disk, w_pend_tmr};

endmodule
